// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a UART receiver and transmitter, with a four-state drain FSM.
// Latency: byte written in cycle N gives tx_en in N+3. Backpressure: writes to a full FIFO are dropped and flagged on overflow.
// Optional UART_FIFO_OVERFLOW_STICKY_EN: overflow latches until reset instead of pulsing once per drop.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_done,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              pop, wr, drop;

  // The pop lands in the LOAD cycle, so a write arriving then may use the slot it frees.
  assign pop  = (state == LOAD);
  assign wr   = rx_valid && (!full || pop);
  assign drop = rx_valid && !wr;

  always_comb begin
    count_nxt = fifo_count;
    if (wr && !pop)
      count_nxt = fifo_count + CNT_ONE;
    else if (pop && !wr)
      count_nxt = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      fifo_count <= count_nxt;
      full       <= (count_nxt == FULL_CNT);
      empty      <= (count_nxt == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_data is captured on entry to LOAD so it is already valid during the LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      tx_en <= (state_nxt == START);
      if (state == IDLE && state_nxt == LOAD)
        tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
`ifdef UART_FIFO_OVERFLOW_STICKY_EN
      overflow <= overflow | drop;
`else
      overflow <= drop;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and random traffic against a queue model.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              tx_done = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic [ADDR_W:0]   fifo_count;
  logic              full, empty, overflow;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done), .fifo_count(fifo_count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: byte queue plus the cycle numbers at which the drain engine acts.
  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         busy;
  int         ready_cyc, load_cyc, en_cyc, wait_cyc;
  logic [7:0] cur;
  bit         ovf_exp;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         done;
    bit         en;
    int         cnt;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    if (cyc == load_cyc) cur = q[0];
    chk("count", int'(fifo_count), q.size());
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("tx_en", int'(tx_en), int'(cyc == en_cyc));
    chk("tx_data", int'(tx_data), int'(cur));
    chk("overflow", int'(overflow), int'(ovf_exp));
    if (tx_en) sent.push_back(tx_data);
  endtask

  // An idle engine that sees stored data loads next cycle and starts the one after.
  task automatic model_decide();
    if (!busy && cyc >= ready_cyc && q.size() > 0) begin
      busy     = 1'b1;
      load_cyc = cyc + 1;
      en_cyc   = cyc + 2;
      wait_cyc = cyc + 3;
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit done);
    bit pop_now, wr_now;
    pop_now = (cyc == load_cyc);
    wr_now  = v && (q.size() < DEPTH || pop_now);
    if (pop_now) void'(q.pop_front());
    if (wr_now) q.push_back(d);
`ifdef UART_FIFO_OVERFLOW_STICKY_EN
    ovf_exp = ovf_exp | (v && !wr_now);
`else
    ovf_exp = v && !wr_now;
`endif
    if (done && busy && cyc >= wait_cyc) begin
      busy      = 1'b0;
      ready_cyc = cyc + 1;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit done);
    rx_valid = v;
    rx_data  = d;
    tx_done  = done;
    model_edge(v, d, done);
    @(posedge clk);
    #1;
    cyc++;
    model_check();
    model_decide();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    #2;
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_tx_en", int'(tx_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    q.delete();
    busy = 1'b0; cur = 8'h00; ovf_exp = 1'b0;
    load_cyc = -1; en_cyc = -1; wait_cyc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    ready_cyc = cyc;
    model_check();
    model_decide();
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((q.size() > 0 || busy) && budget > 0) begin
      step(1'b0, 8'h00, $urandom_range(0, 3) == 0);
      budget--;
    end
    chk("drain_timeout", int'(budget > 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int peak, full_seen, ovf_cycles, en_seen;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'hA5};
    tbl[0]      = '{1'b1, 8'hA5, 1'b0, 1'b0, 0, 8'h00};
    tbl[1]      = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h00};
    tbl[2]      = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hA5};
    tbl[3].en   = 1'b1;
    tbl[10].done = 1'b1;
    tbl[12].done = 1'b1;

    #1;
    do_reset();

    // Single byte: tx_data valid two cycles after the write, tx_en exactly three after.
    for (int i = 0; i < 16; i++) begin
      chk("tbl_tx_en", int'(tx_en), int'(tbl[i].en));
      chk("tbl_count", int'(fifo_count), tbl[i].cnt);
      chk("tbl_tx_data", int'(tx_data), int'(tbl[i].data));
      step(tbl[i].v, tbl[i].d, tbl[i].done);
    end
    chk("tbl_empty_end", int'(empty), 1);

    // Burst of 16 with transmitter stalled: one byte leaves, so 15 remain stored.
    sent.delete();
    peak = 0; full_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (full) full_seen = 1;
    end
    chk("burst_peak", peak, 15);
    chk("burst_full_seen", full_seen, 0);
    drain();
    chk("burst_sent_len", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("burst_order", int'(sent[i]), i);

    // 18 writes with transmitter stalled: FIFO fills, 18th byte dropped.
    peak = 0; ovf_cycles = 0;
    for (int i = 0; i < 22; i++) begin
      step(i < 18, 8'h20 + 8'(i), 1'b0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (overflow) ovf_cycles++;
    end
    chk("ovf_peak", peak, 16);
    chk("ovf_full", int'(full), 1);
`ifdef UART_FIFO_OVERFLOW_STICKY_EN
    chk("ovf_cycles", ovf_cycles, 5);
    chk("ovf_sticky", int'(overflow), 1);
`else
    chk("ovf_cycles", ovf_cycles, 1);
    chk("ovf_pulse_end", int'(overflow), 0);
`endif

    // Full FIFO: release the transmitter, write during the LOAD cycle.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    chk("load_write_count", int'(fifo_count), 16);
    chk("load_write_full", int'(full), 1);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h60 + 8'(i), (i % 4) == 3);
    drain();

    // Reset while a byte is in flight and 5 are stored.
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", int'(fifo_count), 5);
    do_reset();
    en_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, i % 3 == 0);
      if (tx_en) en_seen++;
    end
    chk("post_rst_tx_en", en_seen, 0);

    // Random traffic, varying write density.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < (i / 300) * 2 + 1, 8'($urandom), $urandom_range(0, 4) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, 4 to 256.
REQ-002 Parameter ADDR_W, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Clk  input  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-004 Rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Rx_data  input  8  byte from the UART receiver.
REQ-006 Rx_valid  input  1  one-cycle strobe qualifying Rx_data; driven by the receiver's done pulse.
REQ-007 Tx_data  output  8  byte presented to the UART transmitter.
REQ-008 Tx_en  output  1  one-cycle, registered start pulse to the transmitter.
REQ-009 Tx_done  input  1  one-cycle pulse from the transmitter when the stop bit completes.
REQ-010 Fifo_count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
REQ-011 Full  output  1  high when Fifo_count == DEPTH.
REQ-012 Empty  output  1  high when Fifo_count == 0.
REQ-013 Overflow  output  1  write-dropped indication (see Configuration).

Function
REQ-014 Storage SHALL be a DEPTH x 8 register array with ADDR_W-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-015 A write SHALL occur on a Rx_valid cycle when not Full, or when Full and a pop occurs in the same cycle.
REQ-016 Rx_valid while Full with no same-cycle pop SHALL drop the byte and leave pointers and count unchanged.
REQ-017 Fifo_count SHALL increment on write-only, decrement on pop-only, and hold on simultaneous write+pop or neither.
REQ-018 Drain FSM states: IDLE, LOAD, START, WAIT.
REQ-019 In IDLE with Empty low, the FSM SHALL go to LOAD.
REQ-020 In LOAD, the FSM SHALL pop one byte into the Tx_data register, advance the read pointer, and go to START.
REQ-021 In START, the FSM SHALL assert Tx_en for exactly one cycle and go to WAIT.
REQ-022 In WAIT, the FSM SHALL hold Tx_data stable and, on Tx_done, return to IDLE.
REQ-023 Latency: with the FSM in IDLE and Empty high, a byte written in cycle N SHALL produce Tx_en high in cycle N+3.
REQ-024 Successive Tx_en pulses SHALL be separated by at least 2 cycles after the Tx_done cycle; Tx_en SHALL never be asserted while in WAIT.
REQ-025 Tx_done received outside WAIT SHALL be ignored.
REQ-026 Byte order out SHALL equal byte order in; no byte SHALL be duplicated.
REQ-027 Full and Empty SHALL be registered, consistent with Fifo_count in the same cycle.

Reset
REQ-028 On Rst_n low: pointers=0, Fifo_count=0, Empty=1, Full=0, Overflow=0, Tx_en=0, Tx_data=8'h00, FSM=IDLE, immediately and asynchronously.
REQ-029 Reset asserted during WAIT SHALL abandon the byte in flight; array contents need not be cleared.
REQ-030 After reset release, no Tx_en SHALL occur until a new byte is written.

Configuration
REQ-031 Macro UART_FIFO_OVERFLOW_STICKY_EN defined: Overflow SHALL set on any dropped write and stay high until reset.
REQ-032 Macro UART_FIFO_OVERFLOW_STICKY_EN undefined: Overflow SHALL be a one-cycle pulse in the cycle following each dropped write.

Verification
REQ-033 Reset, then one Rx_valid with 8'hA5 in cycle 10 -> Tx_en high only in cycle 13, Tx_data=8'hA5 from cycle 12; Tx_done in cycle 20 -> FSM IDLE, Empty=1.
REQ-034 Burst of 16 bytes 8'h00..8'h0F on consecutive cycles with Tx_done withheld -> count peaks at 15 (one byte popped), Full never set; bytes transmitted in order 00..0F.
REQ-035 Hold Tx_done low, write 18 bytes -> count reaches 16 and Full=1; 18th byte dropped; Overflow stays high (sticky build) or pulses once (non-sticky build).
REQ-036 Full FIFO, FSM in IDLE, Rx_valid in the LOAD cycle -> write accepted, count stays 16, wrap-around of both pointers verified over 40 bytes.
REQ-037 Rst_n low during WAIT with 5 bytes stored -> count=0, Tx_en=0; no Tx_en after release until a new write.
REQ-038 Tx_done pulse in IDLE with Empty=1 -> no state change, no Tx_en.
